alu_flag_branch_unit: RTL

- Consumer end of the ALU flag interface. Registers the Z/V/N flags the 16-bit ALU emits, per opcode update rules, and resolves conditional branches against them.
- Sits between the EX stage (flag producer) and the fetch/PC logic (branch redirect consumer).
- Provides same-cycle flag forwarding, stall hold, and a registered, valid-qualified branch decision.

---
 rtl/alu_flag_branch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/alu_flag_branch_unit.sv
// Registers the Z/V/N flags produced by the 16-bit ALU and resolves conditional
// branches against them, with optional same-cycle flag forwarding.
module alu_flag_branch_unit #(
  parameter bit FWD_EN   = 1'b1,
  parameter int NUM_COND = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_wr_en,
  input  logic [2:0]  alu_op,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        hold,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  output logic [2:0]  flags_q,
  output logic        br_resp_valid,
  output logic        br_taken,
  output logic [15:0] br_cnt
);

  logic                updAll;
  logic                updZ;
  logic                wrZ;
  logic                wrVN;
  logic [2:0]          flags_d;
  logic [2:0]          effFlags;
  logic                effZ;
  logic                effV;
  logic                effN;
  logic [NUM_COND-1:0] condVec;
  logic                condTaken;
  logic [15:0]         cnt_d;

  // ADD/SUB write all three flags; XOR and the shift/rotate group write only Z.
  always_comb begin
    updAll  = (alu_op == 3'b000) || (alu_op == 3'b001);
    updZ    = updAll || (alu_op == 3'b010) || (alu_op[2] && (alu_op != 3'b111));
    wrZ     = flag_wr_en && updZ;
    wrVN    = flag_wr_en && updAll;
    flags_d = {wrZ  ? alu_z : flags_q[2],
               wrVN ? alu_v : flags_q[1],
               wrVN ? alu_n : flags_q[0]};
  end

  always_comb begin
    effFlags = FWD_EN ? flags_d : flags_q;
    effZ     = effFlags[2];
    effV     = effFlags[1];
    effN     = effFlags[0];
  end

  always_comb begin
    condVec    = '0;
    condVec[0] = !effZ;
    condVec[1] = effZ;
    condVec[2] = !effZ && !effN;
    condVec[3] = effN;
    condVec[4] = effZ || (!effZ && !effN);
    condVec[5] = effN || effZ;
    condVec[6] = effV;
    condVec[7] = 1'b1;
    condTaken  = condVec[br_cond];
  end

  // Taken-branch counter saturates rather than wrapping.
  always_comb begin
    cnt_d = br_cnt;
    if (br_valid && condTaken && (br_cnt != 16'hFFFF)) begin
      cnt_d = br_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q       <= 3'b000;
      br_resp_valid <= 1'b0;
      br_taken      <= 1'b0;
      br_cnt        <= 16'd0;
    end else if (!hold) begin
      flags_q       <= flags_d;
      br_resp_valid <= br_valid;
      br_taken      <= br_valid && condTaken;
      br_cnt        <= cnt_d;
    end
  end

endmodule
